// File: rtl/memory_system.sv
`default_nettype none
// ============================================================================
// Module   : memory_system
// Purpose  : Data-memory subsystem for the WISC MEM stage. It is a 2 KB,
//            2-way set-associative, write-through, write-allocate cache in
//            front of an internal pipelined word memory with a latency of 4.
//            Hits complete in the request cycle. A miss stalls the requester
//            for 13 cycles while an 8-word block fills.
// Revision : 1.0 - initial release
// ============================================================================
module memory_system #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_write,
  input  logic              mem_read,
  input  logic              mem_en,
  input  logic [AWIDTH-1:0] addr_in,
  input  logic [DWIDTH-1:0] data_in,
  output logic [DWIDTH-1:0] data_out,
  output logic              cache_miss_stall
);

  localparam int OFF_W     = 3;
  localparam int IDX_W     = 6;
  localparam int TAG_W     = AWIDTH - 1 - OFF_W - IDX_W;
  localparam int SETS      = 1 << IDX_W;
  localparam int WORDS     = 1 << (IDX_W + OFF_W);
  localparam int MEM_WORDS = 1 << (AWIDTH - 1);
  localparam int LAT       = 4;
  localparam logic [OFF_W:0] CNT_ONE = 1;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_FILL = 1'b1} state_t;

  state_t            state_q;
  logic [SETS-1:0]   valid_q [2];
  logic [SETS-1:0]   lru_q;          // per set: the way to evict next
  logic [TAG_W-1:0]  tag_q   [2][SETS];
  logic [DWIDTH-1:0] data_q  [2][WORDS];
  logic [DWIDTH-1:0] mem_q   [MEM_WORDS];

  // Block being filled, latched at the miss so requester changes cannot disturb it
  logic [TAG_W-1:0]  fill_tag_q;
  logic [IDX_W-1:0]  fill_idx_q;
  logic              fill_way_q;
  logic [OFF_W:0]    issue_cnt_q;    // MSB set once all 8 word reads are issued

  // Memory read pipeline: valid bits, word index and data per stage
  logic [LAT-1:0]    pv_q;
  logic [OFF_W-1:0]  pidx_q  [LAT];
  logic [DWIDTH-1:0] pdata_q [LAT];

  logic [OFF_W-1:0]  off;
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic              req;
  logic [1:0]        way_hit;
  logic              hit;
  logic              hit_way;
  logic              idle;
  logic              rd_hit;
  logic              wr_hit;
  logic              miss;
  logic              victim_d;
  logic              issue;
  logic [AWIDTH-2:0] issue_addr;
  logic              ret;
  logic              fill_done;
  logic              unused_addr_lsb;

  assign unused_addr_lsb = addr_in[0];   // byte lane bit; accesses are word aligned

  assign off = addr_in[OFF_W:1];
  assign idx = addr_in[OFF_W+IDX_W:OFF_W+1];
  assign tag = addr_in[AWIDTH-1:OFF_W+IDX_W+1];

  assign req        = ~rst & mem_en & (mem_read | mem_write);
  assign way_hit[0] = valid_q[0][idx] & (tag_q[0][idx] == tag);
  assign way_hit[1] = valid_q[1][idx] & (tag_q[1][idx] == tag);
  assign hit        = req & (|way_hit);
  assign hit_way    = ~way_hit[0];
  assign idle       = (state_q == S_IDLE);
  assign wr_hit     = idle & hit & mem_write;
  assign rd_hit     = idle & hit & mem_read & ~mem_write;
  assign miss       = idle & req & ~hit;

  // Fill an empty way first (way 0 preferred); otherwise evict the LRU way
  assign victim_d = ~valid_q[0][idx] ? 1'b0 :
                    ~valid_q[1][idx] ? 1'b1 : lru_q[idx];

  assign issue      = (state_q == S_FILL) & ~issue_cnt_q[OFF_W];
  assign issue_addr = {fill_tag_q, fill_idx_q, issue_cnt_q[OFF_W-1:0]};
  assign ret        = pv_q[LAT-1];
  assign fill_done  = (state_q == S_FILL) & ret & (&pidx_q[LAT-1]);

  assign data_out         = rd_hit ? data_q[hit_way][{idx, off}] : '0;
  assign cache_miss_stall = ~rst & ((state_q == S_FILL) | (req & ~hit));

  // Controller: miss handling FSM, valid/LRU bookkeeping, fill issue counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      valid_q[0]  <= '0;
      valid_q[1]  <= '0;
      lru_q       <= '0;
      issue_cnt_q <= '0;
      pv_q        <= '0;
      fill_tag_q  <= '0;
      fill_idx_q  <= '0;
      fill_way_q  <= 1'b0;
    end else begin
      pv_q <= {pv_q[LAT-2:0], issue};
      case (state_q)
        S_IDLE: begin
          if (rd_hit | wr_hit) begin
            lru_q[idx] <= ~hit_way;
          end else if (miss) begin
            fill_tag_q             <= tag;
            fill_idx_q             <= idx;
            fill_way_q             <= victim_d;
            valid_q[victim_d][idx] <= 1'b0;
            issue_cnt_q            <= '0;
            state_q                <= S_FILL;
          end
        end
        S_FILL: begin
          if (issue) issue_cnt_q <= issue_cnt_q + CNT_ONE;
          if (fill_done) begin
            valid_q[fill_way_q][fill_idx_q] <= 1'b1;
            lru_q[fill_idx_q]               <= ~fill_way_q;
            state_q                         <= S_IDLE;
          end
        end
      endcase
    end
  end

  // Main memory: synchronous read into a 4-stage return pipeline, write-through on write hits
  always_ff @(posedge clk) begin
    pidx_q[0]  <= issue_cnt_q[OFF_W-1:0];
    pdata_q[0] <= mem_q[issue_addr];
    for (int s = 1; s < LAT; s++) begin
      pidx_q[s]  <= pidx_q[s-1];
      pdata_q[s] <= pdata_q[s-1];
    end
    if (wr_hit) mem_q[addr_in[AWIDTH-1:1]] <= data_in;
  end

  // Cache arrays: write-hit updates and returning fill words; tag lands with the last word
  always_ff @(posedge clk) begin
    if (wr_hit) begin
      data_q[hit_way][{idx, off}] <= data_in;
    end else if (ret && state_q == S_FILL && !rst) begin
      data_q[fill_way_q][{fill_idx_q, pidx_q[LAT-1]}] <= pdata_q[LAT-1];
    end
    if (fill_done && !rst) tag_q[fill_way_q][fill_idx_q] <= fill_tag_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_memory_system.sv
`default_nettype none
// ============================================================================
// Module   : tb_memory_system
// Purpose  : Scoreboard bench for memory_system. A reference model (2-entry
//            recency list per set plus a sparse word memory) predicts stall
//            length and read data; a negedge monitor compares completions.
// Revision : 1.0 - initial release
// ============================================================================
module tb_memory_system;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_write = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_en = 1'b0;
  logic [15:0] addr_in = '0;
  logic [15:0] data_in = '0;
  logic [15:0] data_out;
  logic        cache_miss_stall;

  memory_system #(.DWIDTH(16), .AWIDTH(16)) dut (
    .clk              (clk),
    .rst              (rst),
    .mem_write        (mem_write),
    .mem_read         (mem_read),
    .mem_en           (mem_en),
    .addr_in          (addr_in),
    .data_in          (data_in),
    .data_out         (data_out),
    .cache_miss_stall (cache_miss_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [15:0] data;
    int          stall;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          scnt   = 0;

  // Reference model: most/least recently used resident tag per set (-1 = empty)
  int          mru_t[64];
  int          lru_t[64];
  logic [15:0] mem_m[int];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_clear();
    for (int s = 0; s < 64; s++) begin
      mru_t[s] = -1;
      lru_t[s] = -1;
    end
  endfunction

  // Returns 1 on a hit and updates recency; a miss installs the tag as MRU
  function automatic bit model_access(logic [15:0] a);
    int s = int'(a[9:4]);
    int t = int'(a[15:10]);
    if (mru_t[s] == t) return 1'b1;
    if (lru_t[s] == t) begin
      lru_t[s] = mru_t[s];
      mru_t[s] = t;
      return 1'b1;
    end
    lru_t[s] = mru_t[s];
    mru_t[s] = t;
    return 1'b0;
  endfunction

  function automatic logic [15:0] model_read(logic [15:0] a);
    int w = int'(a[15:1]);
    return mem_m.exists(w) ? mem_m[w] : 16'h0000;
  endfunction

  // Monitor: a request completes on the first cycle its stall is low
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      chk("reset_stall", {31'd0, cache_miss_stall}, 32'd0);
      chk("reset_data", {16'd0, data_out}, 32'd0);
      scnt = 0;
    end else if (mem_en && (mem_read || mem_write)) begin
      if (cache_miss_stall) begin
        scnt++;
      end else if (sb.size() == 0) begin
        chk("unexpected_completion", 32'd1, 32'd0);
        scnt = 0;
      end else begin
        e = sb.pop_front();
        chk($sformatf("stall_cycles@%04h", e.addr), scnt, e.stall);
        chk($sformatf("%s@%04h", e.wr ? "write_data_out" : "read_data", e.addr),
            {16'd0, data_out}, {16'd0, e.data});
        scnt = 0;
      end
    end else begin
      chk("idle_stall", {31'd0, cache_miss_stall}, 32'd0);
      chk("idle_data", {16'd0, data_out}, 32'd0);
    end
  end

  // Issue one request, hold it until the DUT accepts it, then release
  task automatic do_req(bit wr, logic [15:0] a, logic [15:0] d, bit rd_too);
    exp_t e;
    bit   h;
    bit   done = 1'b0;
    h = model_access(a);
    if (wr) mem_m[int'(a[15:1])] = d;
    e.wr    = wr;
    e.addr  = a;
    e.data  = wr ? 16'h0000 : model_read(a);
    e.stall = h ? 0 : 13;
    sb.push_back(e);
    mem_en    = 1'b1;
    mem_write = wr;
    mem_read  = wr ? rd_too : 1'b1;
    addr_in   = a;
    data_in   = d;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (!cache_miss_stall) done = 1'b1;
    end
    if (!done) begin
      chk($sformatf("timeout@%04h", a), 32'd1, 32'd0);
      void'(sb.pop_back());
    end
    @(posedge clk); #1;
    mem_en    = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  // Idle cycles, mixing mem_en=0 with a pending read and an enabled no-op
  task automatic idle(int n);
    for (int i = 0; i < n; i++) begin
      mem_en    = 1'($urandom_range(0, 1));
      mem_read  = ~mem_en;
      mem_write = 1'b0;
      addr_in   = 16'($urandom);
      @(posedge clk); #1;
    end
    mem_en   = 1'b0;
    mem_read = 1'b0;
  endtask

  // Start a miss, then reset partway through the fill
  task automatic reset_mid_fill(logic [15:0] a);
    void'(model_access(a));
    mem_en   = 1'b1;
    mem_read = 1'b1;
    addr_in  = a;
    repeat (6) @(negedge clk);
    @(posedge clk); #1;
    rst      = 1'b1;
    mem_en   = 1'b0;
    mem_read = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a;
    model_clear();
    @(posedge clk); #1;
    rst = 1'b0;

    do_req(1'b1, 16'h0000, 16'hABCD, 1'b0);
    do_req(1'b0, 16'h0000, 16'h0000, 1'b0);
    do_req(1'b0, 16'h0002, 16'h0000, 1'b0);
    do_req(1'b0, 16'h0400, 16'h0000, 1'b0);
    do_req(1'b0, 16'h0800, 16'h0000, 1'b0);
    do_req(1'b0, 16'h0400, 16'h0000, 1'b0);
    do_req(1'b0, 16'h0000, 16'h0000, 1'b0);
    idle(3);
    do_req(1'b1, 16'h0410, 16'h1234, 1'b1);
    do_req(1'b0, 16'h0410, 16'h0000, 1'b0);
    do_req(1'b0, 16'h0810, 16'h0000, 1'b0);
    do_req(1'b0, 16'h0C10, 16'h0000, 1'b0);
    do_req(1'b0, 16'h0410, 16'h0000, 1'b0);
    do_req(1'b0, 16'h0400, 16'h0000, 1'b0);
    reset_mid_fill(16'h2000);
    idle(2);
    do_req(1'b0, 16'h0400, 16'h0000, 1'b0);
    idle(4);
    do_req(1'b0, 16'h0400, 16'h0000, 1'b0);

    for (int n = 0; n < 250; n++) begin
      a = {6'($urandom_range(0, 3)), 6'($urandom_range(0, 3)),
           3'($urandom_range(0, 7)), 1'($urandom_range(0, 1))};
      if ($urandom_range(0, 2) == 0)
        do_req(1'b1, a, 16'($urandom), 1'($urandom_range(0, 1)));
      else
        do_req(1'b0, a, 16'h0000, 1'b0);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end

    idle(2);
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
